memory_stage: RTL and testbench



---
 rtl/memory_stage.sv | 188 ++++++++++++++++++
 tb/tb_memory_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : pipeline MEM stage, single-outstanding load/store port.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package memory_stage_pkg;
  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       mem;
    logic       iop;
    logic [2:0] fcs_opcode;
  } control_s;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_DONE = 2'd3
  } MEM_state_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ex_valid,
  output logic              o_mem_ready,
  input  control_s          i_control_signal,
  input  logic [XLEN-1:0]   i_alu_result,
  input  logic [XLEN-1:0]   i_store_data,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [XLEN-1:0]   o_dmem_wdata,
  output logic [XLEN/8-1:0] o_dmem_wstrb,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [XLEN-1:0]   o_wb_data,
  output control_s          o_control_signal,
  output logic              o_mem_fault,
  output MEM_state_t        o_current_state
);

  MEM_state_t      state_q, state_d;
  control_s        ctrl_q, ctrl_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            fault_q, fault_d;

  logic            in_width_ok;
  logic            in_misaligned;
  logic            in_fault;
  logic [7:0]      lane_byte;
  logic [15:0]     lane_half;
  logic            load_signed;
  logic [XLEN-1:0] load_value;
  logic [3:0]      store_strb;
  logic [XLEN-1:0] store_wdata;

  // Legality is decided on the incoming bundle so a faulting access never reaches MEM_REQ.
  always_comb begin
    if (i_control_signal.iop) begin
      in_width_ok = i_control_signal.fcs_opcode inside {3'b000, 3'b001, 3'b010};
    end else begin
      in_width_ok = i_control_signal.fcs_opcode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    in_misaligned = ((i_control_signal.fcs_opcode[1:0] == 2'b01) && i_alu_result[0]) ||
                    ((i_control_signal.fcs_opcode[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
    in_fault      = !in_width_ok || in_misaligned;
  end

  always_comb begin
    lane_byte   = i_dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half   = i_dmem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_signed = !ctrl_q.fcs_opcode[2];
    case (ctrl_q.fcs_opcode[1:0])
      2'b00:   load_value = {{(XLEN-8){load_signed & lane_byte[7]}}, lane_byte};
      2'b01:   load_value = {{(XLEN-16){load_signed & lane_half[15]}}, lane_half};
      default: load_value = i_dmem_rdata;
    endcase
  end

  always_comb begin
    case (ctrl_q.fcs_opcode[1:0])
      2'b00: begin
        store_strb  = 4'b0001 << addr_q[1:0];
        store_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        store_strb  = 4'b0011 << addr_q[1:0];
        store_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        store_strb  = 4'b1111;
        store_wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    wb_data_d = wb_data_q;
    fault_d   = fault_q;
    case (state_q)
      MEM_IDLE: begin
        if (i_ex_valid) begin
          ctrl_d    = i_control_signal;
          addr_d    = i_alu_result;
          sdata_d   = i_store_data;
          fault_d   = 1'b0;
          wb_data_d = '0;
          if (!i_control_signal.mem) begin
            wb_data_d = i_alu_result;
            state_d   = MEM_DONE;
          end else if (in_fault) begin
            fault_d = 1'b1;
            state_d = MEM_DONE;
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (i_dmem_gnt) begin
          state_d = ctrl_q.iop ? MEM_DONE : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_rvalid) begin
          wb_data_d = load_value;
          state_d   = MEM_DONE;
        end
      end
      MEM_DONE: begin
        if (i_wb_ready) begin
          state_d = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= MEM_IDLE;
      ctrl_q    <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      wb_data_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      wb_data_q <= wb_data_d;
      fault_q   <= fault_d;
    end
  end

  // Memory-port outputs are pure decodes of state and registered fields.
  assign o_mem_ready      = (state_q == MEM_IDLE);
  assign o_dmem_req       = (state_q == MEM_REQ);
  assign o_dmem_we        = o_dmem_req && ctrl_q.iop;
  assign o_dmem_addr      = o_dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign o_dmem_wdata     = o_dmem_we ? store_wdata : '0;
  assign o_dmem_wstrb     = o_dmem_we ? store_strb : '0;
  assign o_wb_valid       = (state_q == MEM_DONE);
  assign o_wb_data        = wb_data_q;
  assign o_mem_fault      = fault_q;
  assign o_control_signal = ctrl_q;
  assign o_current_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage : self-checking bench for memory_stage.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_ready;
  control_s    ctrl_in;
  logic [31:0] alu;
  logic [31:0] sdata;
  logic        req, we;
  logic [31:0] daddr, wdata;
  logic [3:0]  wstrb;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        wbv;
  logic        wb_ready;
  logic [31:0] wb_data;
  control_s    ctrl_out;
  logic        fault;
  MEM_state_t  state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory_stage #(.XLEN(32)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_ex_valid       (ex_valid),
    .o_mem_ready      (mem_ready),
    .i_control_signal (ctrl_in),
    .i_alu_result     (alu),
    .i_store_data     (sdata),
    .o_dmem_req       (req),
    .o_dmem_we        (we),
    .o_dmem_addr      (daddr),
    .o_dmem_wdata     (wdata),
    .o_dmem_wstrb     (wstrb),
    .i_dmem_gnt       (gnt),
    .i_dmem_rvalid    (rvalid),
    .i_dmem_rdata     (rdata),
    .o_wb_valid       (wbv),
    .i_wb_ready       (wb_ready),
    .o_wb_data        (wb_data),
    .o_control_signal (ctrl_out),
    .o_mem_fault      (fault),
    .o_current_state  (state)
  );

  typedef struct {
    logic        fault;
    logic        req;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] wb;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: access size in bytes, legality list, and arithmetic shifts/masks.
  function automatic exp_t model(input control_s c, input logic [31:0] addr,
                                 input logic [31:0] sd, input logic [31:0] rd);
    exp_t        e;
    int          size;
    int          off;
    bit          legal;
    logic [31:0] v;
    logic [31:0] mask;
    e = '{fault: 1'b0, req: 1'b0, we: 1'b0, strb: 4'h0, wdata: 32'h0, wb: 32'h0};
    if (!c.mem) begin
      e.wb = addr;
      return e;
    end
    size = 1 << c.fcs_opcode[1:0];
    off  = int'(addr[1:0]);
    if (c.iop) legal = (c.fcs_opcode <= 3'd2);
    else       legal = (c.fcs_opcode <= 3'd2) || (c.fcs_opcode == 3'd4) || (c.fcs_opcode == 3'd5);
    if (!legal || (off % size) != 0) begin
      e.fault = 1'b1;
      return e;
    end
    e.req = 1'b1;
    if (c.iop) begin
      e.we   = 1'b1;
      e.strb = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
      v    = (rd >> (8*off)) & mask;
      if (c.fcs_opcode < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
      e.wb = v;
    end
    return e;
  endfunction

  function automatic control_s mk(input bit m, input bit st, input logic [2:0] op);
    control_s c;
    c.rd         = 5'($urandom_range(0, 31));
    c.reg_write  = 1'($urandom_range(0, 1));
    c.mem        = m;
    c.iop        = st;
    c.fcs_opcode = op;
    return c;
  endfunction

  task automatic run_op(input control_s c, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int gnt_dly, input int rv_dly,
                        input int bp, input bit early_rv);
    exp_t        e;
    logic [31:0] data_hold;
    e = model(c, addr, sd, rd);
    for (int k = 0; k < 20 && !mem_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("ready_before", mem_ready, 1'b1);
    ex_valid = 1'b1; ctrl_in = c; alu = addr; sdata = sd;
    @(posedge clk); #1;
    ex_valid = 1'b0; ctrl_in = '0; alu = $urandom; sdata = $urandom;
    if (e.req) begin
      for (int k = 0; k <= gnt_dly; k++) begin
        chk("req_held", req, 1'b1);
        chk("we", we, e.we);
        chk("addr", daddr, {addr[31:2], 2'b00});
        chk("wstrb", wstrb, e.strb);
        chk("wdata", wdata, e.wdata);
        chk("wbv_in_req", wbv, 1'b0);
        if (k == gnt_dly) begin
          gnt = 1'b1;
          if (early_rv && !c.iop) begin rvalid = 1'b1; rdata = ~rd; end
        end
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b0;
      end
      if (!c.iop) begin
        chk("req_drop", req, 1'b0);
        chk("wbv_in_wait", wbv, 1'b0);
        for (int k = 0; k < rv_dly; k++) begin
          @(posedge clk); #1;
          chk("wbv_in_wait", wbv, 1'b0);
        end
        rvalid = 1'b1; rdata = rd;
        @(posedge clk); #1;
        rvalid = 1'b0; rdata = $urandom;
      end
    end
    chk("wb_valid", wbv, 1'b1);
    chk("wb_data", wb_data, e.wb);
    chk("fault", fault, e.fault);
    chk("req_done", req, 1'b0);
    chk("ready_done", mem_ready, 1'b0);
    chk("ctrl_out", 32'(ctrl_out), 32'(c));
    data_hold = wb_data;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk("bp_wbv", wbv, 1'b1);
      chk("bp_data", wb_data, data_hold);
      chk("bp_ready", mem_ready, 1'b0);
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk("ready_after", mem_ready, 1'b1);
    chk("wbv_after", wbv, 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    rst_n = 1'b0; ex_valid = 1'b0; ctrl_in = '0; alu = '0; sdata = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; wb_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(MEM_IDLE));
    chk("rst_ready", mem_ready, 1'b1);
    chk("rst_req", req, 1'b0);
    chk("rst_wbv", wbv, 1'b0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_ctrl", 32'(ctrl_out), 32'h0);
    rst_n = 1'b1;

    // Directed scenarios
    run_op(mk(0, 0, 3'b000), 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 0);           // ADD
    run_op(mk(1, 0, 3'b010), 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);   // LW
    run_op(mk(1, 0, 3'b000), 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);   // LB
    run_op(mk(1, 0, 3'b100), 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0);   // LBU
    run_op(mk(1, 0, 3'b001), 32'h0000_1002, 32'h0, 32'h8001_0000, 0, 0, 0, 0);   // LH
    run_op(mk(1, 1, 3'b000), 32'h0000_1002, 32'h1234_56AB, 32'h0, 3, 0, 0, 0);   // SB slow grant
    run_op(mk(1, 0, 3'b010), 32'h0000_1001, 32'h0, 32'h0, 0, 0, 0, 0);           // misaligned LW
    run_op(mk(1, 0, 3'b011), 32'h0000_1000, 32'h0, 32'h0, 0, 0, 0, 0);           // illegal width
    run_op(mk(1, 1, 3'b010), 32'h0000_2000, 32'hCAFE_F00D, 32'h0, 0, 0, 5, 0);   // SW + backpressure
    run_op(mk(1, 0, 3'b101), 32'h0000_3002, 32'h0, 32'h9ABC_0000, 1, 2, 0, 1);   // LHU, early rvalid

    // Reset while waiting for read data
    ex_valid = 1'b1; ctrl_in = mk(1, 0, 3'b010); alu = 32'h0000_4000;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    chk("pre_rst_state", 32'(state), 32'(MEM_WAIT));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_state", 32'(state), 32'(MEM_IDLE));
    chk("midrst_ready", mem_ready, 1'b1);
    chk("midrst_req", req, 1'b0);
    chk("midrst_we", we, 1'b0);
    chk("midrst_addr", daddr, 32'h0);
    chk("midrst_wdata", wdata, 32'h0);
    chk("midrst_wstrb", wstrb, 4'h0);
    chk("midrst_wbv", wbv, 1'b0);
    chk("midrst_data", wb_data, 32'h0);
    chk("midrst_fault", fault, 1'b0);
    chk("midrst_ctrl", 32'(ctrl_out), 32'h0);
    rvalid = 1'b1; rdata = 32'h1111_2222;
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("late_rvalid_wbv", wbv, 1'b0);
    chk("late_rvalid_state", 32'(state), 32'(MEM_IDLE));

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0: op = 3'b000;
          1: op = 3'b001;
          2: op = 3'b010;
          3: op = 3'b100;
          4: op = 3'b101;
          default: op = 3'($urandom_range(0, 7));
        endcase
      end else begin
        op = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 1) != 0) a[1:0] = 2'b00;
      run_op(mk(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), op), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
